// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row synchroniser, debounce and valid/read handshake
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] RowIn,
    output logic [3:0] ColOut,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_read,
    output logic [1:0] scan_state
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_VALID    = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_state;
    logic [1:0]       r_col;
    logic [1:0]       r_row;
    logic [3:0]       r_pattern;
    logic [DIV_W-1:0] r_div;
    logic [DB_W-1:0]  r_dcnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;

    logic             w_idle;
    logic [1:0]       w_low_row;

    assign w_idle     = (r_sync2 == 4'b1111);
    assign ColOut     = ~(4'b0001 << r_col);
    assign key_code   = r_key_code;
    assign key_valid  = r_key_valid;
    assign scan_state = r_state;

    // Lowest-numbered active row wins when several keys in the column are down
    always_comb begin
        w_low_row = 2'd3;
        if (!r_sync2[0])      w_low_row = 2'd0;
        else if (!r_sync2[1]) w_low_row = 2'd1;
        else if (!r_sync2[2]) w_low_row = 2'd2;
    end

    // Two-flop synchroniser for the asynchronous row lines; idle level is all-high
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= RowIn;
            r_sync2 <= r_sync1;
        end
    end

    // Scan / debounce / hold-until-read / release-qualify state machine
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state     <= ST_SCAN;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_pattern   <= 4'b1111;
            r_div       <= '0;
            r_dcnt      <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (!w_idle) begin
                        // Column and divider freeze here so the pressed key stays driven
                        r_row     <= w_low_row;
                        r_pattern <= r_sync2;
                        r_dcnt    <= DB_W'(1);
                        r_state   <= ST_DEBOUNCE;
                    end else if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        r_col <= r_col + 2'd1;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_sync2 != r_pattern) begin
                        r_state <= ST_SCAN;
                        r_col   <= r_col + 2'd1;
                        r_div   <= '0;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == DB_MAX) begin
                        r_key_code  <= {r_row, r_col};
                        r_key_valid <= 1'b1;
                        r_state     <= ST_VALID;
                        r_dcnt      <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + DB_W'(1);
                    end
                end
                ST_VALID: begin
                    // Key release is ignored here; only the consumer clears the key
                    if (key_read) begin
                        r_key_valid <= 1'b0;
                        r_state     <= ST_RELEASE;
                        r_dcnt      <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (!w_idle) begin
                        r_dcnt <= '0;
                    end else if (r_dcnt == DB_LAST) begin
                        r_state <= ST_SCAN;
                        r_col   <= r_col + 2'd1;
                        r_div   <= '0;
                        r_dcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + DB_W'(1);
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       nRST;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_read;
    logic [1:0] scan_state;

    logic [15:0] keys;
    logic [3:0]  force_low;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          q_code[$];
    int          q_cyc[$];
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: a pressed key (row r, col c) pulls row r low while column c is driven low
    always_comb begin
        RowIn = 4'b1111;
        for (int r = 0; r < 4; r++)
            RowIn[r] = ~(|(keys[r*4 +: 4] & ~ColOut)) & ~force_low[r];
    end

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .RowIn     (RowIn),
        .ColOut    (ColOut),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_read  (key_read),
        .scan_state(scan_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: every rising key_valid must match the oldest expected press
    always @(negedge clk) begin
        int e_code;
        int e_cyc;
        if (key_valid === 1'b1 && !prev_valid) begin
            if (q_code.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: key_valid rose with code %0d, expected no press (cycle %0d)", key_code, cyc);
            end else begin
                e_code = q_code.pop_front();
                e_cyc  = q_cyc.pop_front();
                check("key_code", key_code, e_code);
                if (e_cyc >= 0) check("valid_latency_edge", cyc, e_cyc);
            end
        end
        prev_valid = (key_valid === 1'b1);
    end

    task automatic wait_col(input logic [3:0] target, input string name);
        int k;
        for (k = 0; k < 64 && ColOut === target; k++) @(negedge clk);
        for (k = 0; k < 64; k++) begin
            if (ColOut === target) break;
            @(negedge clk);
        end
        if (k == 64) timeout(name);
    endtask

    task automatic wait_valid(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            if (key_valid === 1'b1) break;
            @(negedge clk);
        end
        if (k == 100) timeout(name);
    endtask

    task automatic wait_state(input logic [1:0] target, input string name, output int k);
        for (k = 0; k < 200; k++) begin
            if (scan_state === target) break;
            @(negedge clk);
        end
        if (k == 200) timeout(name);
    endtask

    task automatic ack(input string name);
        key_read = 1'b1;
        @(negedge clk);
        key_read = 1'b0;
        check({name, "_valid_drop"}, key_valid, 0);
        check({name, "_state_release"}, scan_state, 3);
    endtask

    initial begin
        int         k;
        int         e0;
        logic [3:0] one;
        logic [3:0] exp_col;

        nRST      = 1'b0;
        key_read  = 1'b0;
        keys      = 16'h0000;
        force_low = 4'b1111;
        repeat (3) @(negedge clk);
        check("reset_colout", ColOut, 4'b1110);
        check("reset_valid", key_valid, 0);
        check("reset_code", key_code, 0);
        check("reset_state", scan_state, 0);

        nRST      = 1'b1;
        force_low = 4'b0000;
        wait_col(4'b1101, "scan_to_col1");
        for (int i = 0; i < 16; i++) begin
            one     = 4'b0001 << ((1 + i / 4) % 4);
            exp_col = ~one;
            check("scan_step", ColOut, exp_col);
            @(negedge clk);
        end

        // Key 15 held before column 3 is selected: latency measured from that selection
        wait_col(4'b1110, "k15_col0");
        keys[15] = 1'b1;
        wait_col(4'b0111, "k15_col3");
        e0 = cyc;
        q_code.push_back(15);
        q_cyc.push_back(e0 + 11);
        wait_valid("k15_valid");
        check("k15_colout_frozen", ColOut, 4'b0111);
        check("k15_state_valid", scan_state, 2);
        ack("k15_ack");
        keys = 16'h0000;
        wait_state(2'd0, "k15_release", k);
        check("k15_release_cycles", k, 10);

        // Three-cycle glitch on row 0 while column 2 is active
        wait_col(4'b1011, "glitch_col2");
        force_low = 4'b0001;
        repeat (3) @(negedge clk);
        check("glitch_in_debounce", scan_state, 1);
        force_low = 4'b0000;
        wait_state(2'd0, "glitch_back_to_scan", k);
        check("glitch_next_col", ColOut, 4'b0111);
        check("glitch_no_valid", key_valid, 0);

        // Key 5 held long without acknowledge, then released before the read
        q_code.push_back(5);
        q_cyc.push_back(-1);
        keys[5] = 1'b1;
        wait_valid("k5_valid");
        repeat (200) @(negedge clk);
        check("k5_held_valid", key_valid, 1);
        check("k5_held_code", key_code, 5);
        keys = 16'h0000;
        repeat (20) @(negedge clk);
        check("k5_valid_after_release", key_valid, 1);
        check("k5_state_after_release", scan_state, 2);
        ack("k5_ack");
        repeat (40) @(negedge clk);
        check("k5_no_second_valid", key_valid, 0);

        // Key 2 held after acknowledge must not repeat; a fresh press is accepted
        q_code.push_back(2);
        q_cyc.push_back(-1);
        keys[2] = 1'b1;
        wait_valid("k2_valid");
        ack("k2_ack");
        repeat (100) @(negedge clk);
        check("k2_held_in_release", scan_state, 3);
        check("k2_held_no_valid", key_valid, 0);
        keys = 16'h0000;
        wait_state(2'd0, "k2_release", k);
        q_code.push_back(2);
        q_cyc.push_back(-1);
        keys[2] = 1'b1;
        wait_valid("k2_second_valid");
        check("k2_second_code", key_code, 2);
        ack("k2_second_ack");
        keys = 16'h0000;
        wait_state(2'd0, "k2_second_release", k);

        // Rows 1 and 3 both low in column 3: lowest row wins
        q_code.push_back(7);
        q_cyc.push_back(-1);
        keys[7]  = 1'b1;
        keys[15] = 1'b1;
        wait_valid("multi_valid");
        check("multi_code", key_code, 7);
        ack("multi_ack");
        keys = 16'h0000;
        wait_state(2'd0, "multi_release", k);

        // Reset asserted while debouncing key 0
        keys[0] = 1'b1;
        wait_state(2'd1, "rst_enter_debounce", k);
        nRST = 1'b0;
        @(negedge clk);
        check("midrst_colout", ColOut, 4'b1110);
        check("midrst_valid", key_valid, 0);
        check("midrst_state", scan_state, 0);
        check("midrst_code", key_code, 0);
        keys = 16'h0000;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        repeat (40) @(negedge clk);
        check("scoreboard_drained", q_code.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front-end stage of the calculator: drives the 4x4 keypad columns and samples the rows.
- Synchronises and debounces the row inputs, then presents one key index per physical press to the downstream input controller.
- Uses a valid/read handshake with the controller.
- Emits raw index row*4+col; mapping the index to a digit or operator is done downstream.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven before advancing (>=1).
- DEBOUNCE_CYCLES, 8: consecutive stable synchronised samples required to accept a press or a release (>=1).

Ports:
- clk  in  1  system clock
- nRST  in  1  synchronous active-low reset
- RowIn  in  4  keypad rows, active-low, asynchronous to clk
- ColOut  out  4  keypad column drive, active-low one-hot
- key_code  out  4  key index = row*4 + col
- key_valid  out  1  key_code holds a debounced press not yet consumed
- key_read  in  1  consumer acknowledge; meaningful only while key_valid=1
- scan_state  out  2  FSM state (SCAN=0, DEBOUNCE=1, VALID=2, RELEASE=3), for bench observation

Behaviour:
- Reset (nRST=0 at posedge, synchronous): ColOut=4'b1110 (col 0), key_code=0, key_valid=0, scan_state=SCAN, all counters=0, synchroniser flops=4'b1111. Reset overrides every other event, including mid-debounce or during VALID.
- Sampling: RowIn passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- SCAN state:
  - Column counter drives ColOut = ~(1<<col).
  - Divider counts 0..SCAN_DIV-1; on wrap, col = (col+1) mod 4 (3 wraps to 0).
  - If rs != 4'b1111: latch row = lowest-numbered low bit of rs, latch col, freeze ColOut and divider, go to DEBOUNCE with debounce count=1.
- DEBOUNCE state:
  - If rs equals the pattern captured on entry, increment the count.
  - When the count reaches DEBOUNCE_CYCLES: set key_code = row*4+col, set key_valid=1 on the next edge, go to VALID.
  - If rs changes at any point (glitch, release or different row): discard the key, go to SCAN, advance to the next column, no key_valid.
- VALID state:
  - key_valid=1 and key_code held stable.
  - key_read=1 sampled at posedge: key_valid=0 on that edge, go to RELEASE.
  - Release of the key while in VALID is ignored; key_valid stays high until key_read.
- RELEASE state:
  - ColOut stays frozen.
  - Wait for rs==4'b1111 for DEBOUNCE_CYCLES consecutive cycles; any low sample restarts the count.
  - Then go to SCAN, advance the column, restart the divider.
  - A held key never produces a second key_valid (no auto-repeat).
- key_read while key_valid=0 is ignored.
- Multiple keys pressed in one column: lowest row wins. Keys in other columns are invisible because ColOut is frozen.
- Latency, key held from before its column becomes active: key_valid rises exactly DEBOUNCE_CYCLES+3 edges after the first edge at which ColOut selects that column with RowIn low (2 sync + 1 detect + debounce).
- key_valid deasserts on the same edge key_read is sampled; the earliest next press is accepted after the release is qualified.

Test Plan:
- Reset: hold nRST=0 three cycles with RowIn=0000 -> ColOut=1110, key_valid=0, key_code=0, scan_state=0. After release, ColOut steps 1110->1101->1011->0111->1110, each held SCAN_DIV=4 cycles.
- Single press of key 15 (row 3 driven low only while ColOut=0111) -> key_valid=1 with key_code=15 exactly 11 edges after first detection; ColOut stays 0111. Pulse key_read one cycle -> key_valid=0 on that edge, scan_state=3. Release RowIn=1111 -> SCAN after 8 stable cycles.
- Glitch: row 0 low for 3 cycles at col 2, then high -> no key_valid, return to SCAN, next ColOut=0111.
- Held key, no ack: press key 5 and hold 200 cycles without key_read -> key_valid stays 1, key_code=5. Release, then key_read -> key_valid drops, no second assertion.
- Hold after ack: press key 2, ack, keep holding 100 cycles -> exactly one key_valid pulse. Release, press key 2 again -> second valid, key_code=2.
- Multi-row and mid-operation reset: rows 1 and 3 low at col 3 -> key_code=7. Then, in a new press, assert nRST=0 during DEBOUNCE -> next edge shows ColOut=1110, key_valid=0, scan_state=0.
